intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Interrupt requester/controller peripheral that drives the processor's interrupt input and consumes the int_ack handshake from the processor's interrupt encoder.
- Latches up to NSRC peripheral interrupt sources into a pending register and applies a software-writable mask.
- Selects the highest-priority source, raises interrupt, and presents a handler vector address.
- Holds off further requests until software signals end-of-interrupt (EOI) through a memory-mapped write.

Parameters:
- NSRC, 4, number of interrupt sources (1..8).
- VEC_BASE, 32'h0000_0100, vector address for source 0.
- VEC_STRIDE, 32'h10, byte spacing between consecutive vectors.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- irq_src  input  NSRC  raw peripheral interrupt lines.
- int_ack  input  1  acknowledge from the processor's interrupt encoder.
- interrupt  output  1  request to the processor.
- vector  output  32  handler address for the active source.
- we  input  1  register write enable.
- addr  input  2  register select.
- wd  input  32  write data.
- rd  output  32  read data (combinational).

Behaviour:
- Reset (synchronous, active-high): state IDLE; interrupt=0; mask=0 (all sources disabled); pending=0; active_id=0; vector=VEC_BASE; edge history=0.
- Register map:
  - addr 0: MASK, R/W, bits[NSRC-1:0].
  - addr 1: PENDING, read-only.
  - addr 2: EOI, write-only; any write with we=1 counts as EOI; reads return 0.
  - addr 3: ACTIVE, read-only; {state==SERVICE, active_id}.
- Pending capture: each cycle, pending[i] is set when src_event[i]=1. src_event follows INTC_EDGE_DETECT_EN.
- If a set and a clear of the same bit occur in the same cycle, set wins.
- Priority: lowest index wins among (pending & mask).
- State machine:
  - IDLE: if (pending & mask) != 0, go to REQ next cycle. In that cycle latch active_id = highest-priority index and vector = VEC_BASE + active_id*VEC_STRIDE (32-bit, wrap ignored).
  - REQ: interrupt=1. On int_ack=1, clear pending[active_id] and go to SERVICE. The request is committed: a MASK write during REQ does not retract it.
  - SERVICE: interrupt=0. vector and active_id are held. An EOI write goes to IDLE; a new arbitration can then start on the following cycle.
- Latency: source event at cycle N, pending at N+1, REQ (interrupt=1) at N+2.
- EOI written in IDLE or REQ is ignored.
- int_ack outside REQ is ignored.
- A reset mid-operation returns the block to IDLE and loses all pending bits.
- MASK write takes effect the cycle after the write.

Optional Feature:
- Macro INTC_EDGE_DETECT_EN.
- Defined: src_event[i] = irq_src[i] & ~irq_src_d[i], where irq_src_d is a registered copy reset to 0. Only rising edges set pending, so a held-high line sets pending once.
- Undefined: src_event = irq_src (level-sensitive). A held-high line re-sets pending after the ack clear; the source must deassert before EOI to avoid re-entry.

Decomposition:
- Shared package intr_pkg holds:
  - state encoding: IDLE=2'b00, REQ=2'b01, SERVICE=2'b10;
  - register address constants: ADDR_MASK=0, ADDR_PEND=1, ADDR_EOI=2, ADDR_ACTIVE=3;
  - default VEC_BASE and VEC_STRIDE.
- One sub-module, intr_prio_enc: combinational lowest-index priority encoder with NSRC-bit input, id and valid outputs.

Test Plan:
- Reset, then irq_src=4'b0001 with MASK=0 -> PENDING reads 1, interrupt stays 0 for 10 cycles.
- Write MASK=4'hF; pulse irq_src[2] -> interrupt=1 two cycles later, vector=32'h120; int_ack -> interrupt=0, PENDING[2]=0, ACTIVE reads {1,2}.
- Pulse irq_src[3] and irq_src[1] in the same cycle -> source 1 served first (vector=32'h110). After int_ack and EOI, source 3 is served (vector=32'h130).
- In SERVICE, pulse irq_src[0] -> interrupt stays 0 until EOI; one cycle after EOI the FSM enters REQ with vector=32'h100.
- Assert reset while in REQ -> next cycle interrupt=0, PENDING=0, MASK=0, state IDLE.
- INTC_EDGE_DETECT_EN defined: hold irq_src[0]=1 for 20 cycles -> exactly one REQ/ack/EOI sequence. Undefined: a second REQ follows the EOI.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// register map addresses and default vector layout.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } intr_state_t;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_EOI    = 2'd2;
  localparam logic [1:0] ADDR_ACTIVE = 2'd3;

  localparam logic [31:0] VEC_BASE_DFLT   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DFLT = 32'h0000_0010;

  // Source-index width; a single source still needs one id bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational lowest-index-wins priority encoder over the eligible
// (pending & mask) interrupt sources.
module intr_prio_enc
  import intr_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int IDW  = id_width(NSRC)
) (
  input  logic [NSRC-1:0] req,
  output logic [IDW-1:0]  id,
  output logic            valid
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = IDW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: pending/mask registers, priority arbitration,
// REQ/ack/EOI handshake. Define INTC_EDGE_DETECT_EN for rising-edge capture.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int          NSRC       = 4,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DFLT,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DFLT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic            int_ack,
  output logic            interrupt,
  output logic [31:0]     vector,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wd,
  output logic [31:0]     rd
);

  localparam int IDW = id_width(NSRC);

  intr_state_t     state, state_nxt;
  logic [NSRC-1:0] mask, pending, src_event, ack_clr;
  logic [IDW-1:0]  active_id, enc_id;
  logic            enc_valid, eoi_wr, ack_take;
  logic            unused_wd;

  assign unused_wd = ^wd[31:NSRC];

`ifdef INTC_EDGE_DETECT_EN
  logic [NSRC-1:0] irq_src_d;

  always_ff @(posedge clk) begin
    if (reset) irq_src_d <= '0;
    else       irq_src_d <= irq_src;
  end

  assign src_event = irq_src & ~irq_src_d;
`else
  assign src_event = irq_src;
`endif

  assign eoi_wr   = we && (addr == ADDR_EOI);
  assign ack_take = (state == REQ) && int_ack;
  assign ack_clr  = ack_take ? (NSRC'(1) << active_id) : '0;

  intr_prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_prio_enc (
    .req   (pending & mask),
    .id    (enc_id),
    .valid (enc_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enc_valid) state_nxt = REQ;
      REQ:     if (int_ack)   state_nxt = SERVICE;
      SERVICE: if (eoi_wr)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign interrupt = (state == REQ);

  // A new event on the bit being acknowledged wins over the ack clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask      <= '0;
      pending   <= '0;
      active_id <= '0;
      vector    <= VEC_BASE;
    end else begin
      pending <= (pending & ~ack_clr) | src_event;
      if (we && (addr == ADDR_MASK)) mask <= wd[NSRC-1:0];
      if ((state == IDLE) && enc_valid) begin
        active_id <= enc_id;
        vector    <= VEC_BASE + 32'(enc_id) * VEC_STRIDE;
      end
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      ADDR_MASK:   rd[NSRC-1:0] = mask;
      ADDR_PEND:   rd[NSRC-1:0] = pending;
      ADDR_ACTIVE: rd[IDW:0]    = {state == SERVICE, active_id};
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus random traffic
// against a behavioural model; honours INTC_EDGE_DETECT_EN.
module tb_intr_ctrl;

  localparam int          NSRC = 4;
  localparam logic [31:0] VB   = 32'h0000_0100;
  localparam logic [31:0] VS   = 32'h0000_0010;
`ifdef INTC_EDGE_DETECT_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, int_ack, we, interrupt;
  logic [NSRC-1:0] irq_src;
  logic [1:0]      addr;
  logic [31:0]     wd, rd, vector;

  always #5 clk = ~clk;

  intr_ctrl #(.NSRC(NSRC), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .int_ack   (int_ack),
    .interrupt (interrupt),
    .vector    (vector),
    .we        (we),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = in service.
  bit m_pend[NSRC];
  bit m_mask[NSRC];
  bit m_prev[NSRC];
  int m_phase = 0;
  int m_id    = 0;

  function automatic logic [31:0] pack(input bit a[NSRC]);
    logic [31:0] v = 0;
    for (int i = 0; i < NSRC; i++) if (a[i]) v = v + (32'd1 << i);
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return pack(m_mask);
      2'd1:    return pack(m_pend);
      2'd3:    return (m_phase == 2 ? 32'd4 : 32'd0) + 32'(m_id);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int  clr = -1;
    bit  found = 0;
    if (reset) begin
      for (int i = 0; i < NSRC; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
      end
      m_phase = 0;
      m_id    = 0;
    end else begin
      if (m_phase == 0) begin
        for (int i = 0; i < NSRC; i++)
          if (!found && m_pend[i] && m_mask[i]) begin
            found = 1; m_id = i; m_phase = 1;
          end
      end else if (m_phase == 1) begin
        if (int_ack) begin clr = m_id; m_phase = 2; end
      end else begin
        if (we && addr == 2'd2) m_phase = 0;
      end
      for (int i = 0; i < NSRC; i++) begin
        bit ev = irq_src[i] && !(EDGE_MODE && m_prev[i]);
        if (i == clr) m_pend[i] = 0;
        if (ev)       m_pend[i] = 1;
        if (we && addr == 2'd0) m_mask[i] = wd[i];
        m_prev[i] = irq_src[i];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("interrupt", {31'd0, interrupt}, (m_phase == 1) ? 32'd1 : 32'd0);
    check("vector", vector, VB + 32'(m_id) * VS);
    check("rd", rd, exp_rd(addr));
  endtask

  task automatic rd_at(input logic [1:0] a, input string tag, input logic [31:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d);
    addr = a; wd = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  int  reqs;
  bit  prev_int, eoi_next;

  initial begin
    reset = 1'b1; irq_src = '0; int_ack = 1'b0; we = 1'b0; addr = '0; wd = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_int", {31'd0, interrupt}, 32'd0);
    check("rst_vec", vector, 32'h100);
    rd_at(2'd0, "rst_mask", 32'd0);
    rd_at(2'd1, "rst_pend", 32'd0);
    rd_at(2'd3, "rst_active", 32'd0);

    // Masked source: latched as pending, never requested.
    irq_src = 4'b0001; tick(); irq_src = '0;
    repeat (10) begin
      tick();
      check("masked_int", {31'd0, interrupt}, 32'd0);
    end
    rd_at(2'd1, "masked_pend", 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;

    // Single source 2: two-cycle latency, ack, ACTIVE readback.
    write(2'd0, 32'hF);
    irq_src = 4'b0100; tick(); irq_src = '0;
    check("s2_lat1", {31'd0, interrupt}, 32'd0);
    tick();
    check("s2_int", {31'd0, interrupt}, 32'd1);
    check("s2_vec", vector, 32'h120);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("s2_ack_int", {31'd0, interrupt}, 32'd0);
    rd_at(2'd1, "s2_pend", 32'd0);
    rd_at(2'd3, "s2_active", 32'h6);
    write(2'd2, 32'd0);

    // Sources 1 and 3 together: 1 first, then 3 after EOI.
    irq_src = 4'b1010; tick(); irq_src = '0;
    tick();
    check("s13_int_a", {31'd0, interrupt}, 32'd1);
    check("s13_vec_a", vector, 32'h110);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    write(2'd2, 32'd0);
    tick();
    check("s13_int_b", {31'd0, interrupt}, 32'd1);
    check("s13_vec_b", vector, 32'h130);
    int_ack = 1'b1; tick(); int_ack = 1'b0;

    // New source while in service waits for EOI.
    irq_src = 4'b0001; tick(); irq_src = '0;
    repeat (3) begin
      tick();
      check("svc_hold_int", {31'd0, interrupt}, 32'd0);
    end
    write(2'd2, 32'd0);
    check("eoi_idle_int", {31'd0, interrupt}, 32'd0);
    tick();
    check("eoi_req_int", {31'd0, interrupt}, 32'd1);
    check("eoi_req_vec", vector, 32'h100);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    write(2'd2, 32'd0);

    // Reset while requesting.
    irq_src = 4'b0010; tick(); irq_src = '0;
    tick();
    check("pre_rst_int", {31'd0, interrupt}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_int", {31'd0, interrupt}, 32'd0);
    check("mid_rst_vec", vector, 32'h100);
    rd_at(2'd1, "mid_rst_pend", 32'd0);
    rd_at(2'd0, "mid_rst_mask", 32'd0);
    rd_at(2'd3, "mid_rst_active", 32'd0);

    // Held-high source 0 with an auto-responding handler.
    write(2'd0, 32'hF);
    reqs = 0; prev_int = 1'b0; eoi_next = 1'b0;
    for (int c = 0; c < 30; c++) begin
      irq_src = (c < 20) ? 4'b0001 : 4'b0000;
      int_ack = interrupt;
      we      = eoi_next;
      addr    = eoi_next ? 2'd2 : 2'd0;
      eoi_next = interrupt;
      tick();
      if (c < 20 && interrupt && !prev_int) reqs++;
      prev_int = interrupt;
    end
    int_ack = 1'b0; we = 1'b0; irq_src = '0;
    if (EDGE_MODE) check("hold_reqs", 32'(reqs), 32'd1);
    else           check("hold_reqs_multi", (reqs >= 2) ? 32'd1 : 32'd0, 32'd1);

    // Random traffic against the model.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 800; c++) begin
      reset   = ($urandom_range(0, 99) == 0);
      irq_src = ($urandom_range(0, 99) < 20) ? NSRC'($urandom) : '0;
      int_ack = ($urandom_range(0, 2) == 0);
      we      = ($urandom_range(0, 3) == 0);
      addr    = 2'($urandom);
      wd      = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
